fib_run_ctrl: RTL and testbench
===============================

Name: fib_run_ctrl

Overview:
Sequencer for the Fibonacci datapath behind the Wishbone control block. It consumes the block's `switch` and `clock_sel` outputs plus start/stop pulses, and derives a step tick from a one-hot prescaler select. On each tick it advances a Fibonacci pair and counts terms. It stops on a programmed term limit or on width overflow, and raises one-cycle IRQ pulses for the Wishbone IRQ lines.

Parameters:
VALUE_WIDTH, 30, width of Fibonacci value registers (matches `buf_io_out[37:8]`).
CLOCK_WIDTH, 6, width of the one-hot prescaler select.
COUNT_WIDTH, 16, width of the term counter and term limit.

Ports:
wb_clk_i  in  1  single clock for the whole block
reset  in  1  asynchronous, active-high reset
switch  in  1  run enable; low pauses the sequence
clock_sel  in  CLOCK_WIDTH  one-hot tick-rate select
start  in  1  one-cycle pulse: load seeds and run
stop  in  1  one-cycle pulse: abort to IDLE
term_limit  in  COUNT_WIDTH  number of terms to run; 0 = free-run; sampled on accepted start
fib_value  out  VALUE_WIDTH  current term F(n)
term_count  out  COUNT_WIDTH  n, the number of completed steps
state_o  out  3  IDLE=0, RUN=1, PAUSE=2, DONE=3, OVF=4
busy  out  1  state is RUN or PAUSE
irq_done  out  1  one-cycle pulse on entry to DONE
irq_ovf  out  1  one-cycle pulse on entry to OVF

Behaviour:
- Clock and reset: one clock, `wb_clk_i`. Reset is asynchronous and active-high on `reset`.
- Reset values:
  - state IDLE.
  - cur = 0, nxt = 1, so `fib_value` = 0.
  - `term_count` = 0.
  - prescaler = 0, latched limit = 0.
  - `busy`, `irq_done`, `irq_ovf` = 0.
- Reset mid-run returns all of the above immediately. There is no pending-tick carryover.
- Tick generation:
  - The prescaler is a free-running up-counter of CLOCK_WIDTH-1 bits. It counts only in RUN and is cleared on an accepted start.
  - k = index of the lowest set bit of `clock_sel`. tick = 1 when the prescaler's low k bits are all 1. For k = 0 this is every RUN cycle.
  - Period = 2^k cycles. `clock_sel` = 0 never ticks; RUN is held with no progress.
  - A change of `clock_sel` mid-run takes effect on the next cycle without clearing the prescaler.
- Accepted start: `start` = 1 and `switch` = 1 and `stop` = 0, in any state.
  - Next cycle: state RUN, cur = 0, nxt = 1, `term_count` = 0, limit latched from `term_limit`, prescaler = 0.
  - `start` with `switch` = 0 is ignored.
- Step, on tick in RUN:
  - sum = cur + nxt, computed VALUE_WIDTH+1 bits wide.
  - No carry: cur <= nxt, nxt <= sum[VALUE_WIDTH-1:0], `term_count` +1.
  - Carry out: no register update, next state OVF.
- Completion: if limit ≠ 0 and the incremented `term_count` equals the limit, next state DONE, taken on the same edge as the update.
- `term_count` saturates at all-ones in free-run and keeps running.
- Pause and resume: RUN with `switch` = 0 goes to PAUSE; the prescaler freezes and no ticks occur. PAUSE with `switch` = 1 returns to RUN and resumes counting from the frozen prescaler.
- Stop: `stop` in RUN, PAUSE, DONE or OVF goes to IDLE. `fib_value` and `term_count` are retained.
- Simultaneous events: `stop` beats `start`, and `stop` beats tick (no update that cycle). A tick and `switch` falling in the same cycle: the tick is applied, then PAUSE.
- DONE and OVF are terminal and hold all values. Leave them only by `stop`, an accepted start, or reset.
- IRQs: `irq_done` and `irq_ovf` are registered and high exactly one cycle, on the first cycle the new state is visible. Re-entry after a restart pulses again.
- Outputs: `fib_value` = cur, all outputs registered. An accepted start in cycle N gives state RUN in N+1; with k = 0 the first step is applied at the end of N+1, so `fib_value` = 1 in N+2.

Test Plan:
1. Reset, then `switch` = 1, `clock_sel` = 6'b000001, `term_limit` = 10, start pulse → after 10 ticks `fib_value` = 55, `term_count` = 10, state DONE, `irq_done` high 1 cycle, `busy` = 0.
2. `clock_sel` = 6'b000100, `term_limit` = 3, start → steps exactly every 4 cycles, `fib_value` sequence 1, 1, 2; DONE reached 12 cycles after RUN entry.
3. `term_limit` = 0, k = 0, run to overflow → halts with `fib_value` = 433494437 (F(43)), `term_count` = 43, state OVF, one `irq_ovf` pulse, no further change.
4. Mid-run drop `switch` for 20 cycles → state PAUSE, `fib_value` and `term_count` frozen; raise `switch` → RUN, progress resumes on the prescaler phase where it stopped.
5. `start` and `stop` asserted the same cycle while in RUN → IDLE with values retained; `start` with `switch` = 0 from IDLE → ignored, stays IDLE.
6. Assert `reset` asynchronously mid-RUN, between clock edges → outputs immediately 0 (`fib_value`), 0 (`term_count`), IDLE, no IRQ pulse after release.

Source files
------------

// File: rtl/fib_run_ctrl.sv
// Fibonacci run sequencer: prescaled step tick, term limit / overflow stop,
// pause/resume on switch, and one-cycle IRQ pulses on DONE and OVF entry.
module fib_run_ctrl #(
    parameter int VALUE_WIDTH = 30,
    parameter int CLOCK_WIDTH = 6,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    input  logic                   switch,
    input  logic [CLOCK_WIDTH-1:0] clock_sel,
    input  logic                   start,
    input  logic                   stop,
    input  logic [COUNT_WIDTH-1:0] term_limit,
    output logic [VALUE_WIDTH-1:0] fib_value,
    output logic [COUNT_WIDTH-1:0] term_count,
    output logic [2:0]             state_o,
    output logic                   busy,
    output logic                   irq_done,
    output logic                   irq_ovf
);

    localparam int PW = CLOCK_WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3,
        S_OVF   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [VALUE_WIDTH-1:0] cur_q, cur_d, nxt_q, nxt_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, limit_q, limit_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   busy_q, busy_d;
    logic                   irq_done_q, irq_done_d;
    logic                   irq_ovf_q, irq_ovf_d;

    logic [PW-1:0]          tick_mask;
    logic                   sel_any;
    logic                   tick;
    logic                   start_ok;
    logic [VALUE_WIDTH:0]   sum;
    logic [COUNT_WIDTH-1:0] cnt_inc;

    // Mask covers the prescaler bits below the lowest set select bit.
    always_comb begin
        tick_mask = '0;
        sel_any   = 1'b0;
        for (int i = CLOCK_WIDTH - 1; i >= 0; i--) begin
            if (clock_sel[i]) begin
                sel_any   = 1'b1;
                tick_mask = PW'((32'd1 << i) - 32'd1);
            end
        end
    end

    assign tick     = (state_q == S_RUN) && sel_any && ((presc_q & tick_mask) == tick_mask);
    assign start_ok = start && switch && !stop;
    assign sum      = {1'b0, cur_q} + {1'b0, nxt_q};
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        presc_d = presc_q;
        if (state_q == S_RUN) begin
            presc_d = presc_q + 1'b1;
        end

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            state_d = S_RUN;
            cur_d   = '0;
            nxt_d   = {{(VALUE_WIDTH-1){1'b0}}, 1'b1};
            cnt_d   = '0;
            limit_d = term_limit;
            presc_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (tick && sum[VALUE_WIDTH]) begin
                        state_d = S_OVF;
                    end else begin
                        if (tick) begin
                            cur_d = nxt_q;
                            nxt_d = sum[VALUE_WIDTH-1:0];
                            cnt_d = cnt_inc;
                        end
                        // A completing step wins over a falling switch.
                        if (tick && (limit_q != '0) && (cnt_inc == limit_q)) begin
                            state_d = S_DONE;
                        end else if (!switch) begin
                            state_d = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (switch) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d     = (state_d == S_RUN) || (state_d == S_PAUSE);
        irq_done_d = (state_d == S_DONE) && (state_q != S_DONE);
        irq_ovf_d  = (state_d == S_OVF) && (state_q != S_OVF);
    end

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            nxt_q      <= {{(VALUE_WIDTH-1){1'b0}}, 1'b1};
            cnt_q      <= '0;
            limit_q    <= '0;
            presc_q    <= '0;
            busy_q     <= 1'b0;
            irq_done_q <= 1'b0;
            irq_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            cnt_q      <= cnt_d;
            limit_q    <= limit_d;
            presc_q    <= presc_d;
            busy_q     <= busy_d;
            irq_done_q <= irq_done_d;
            irq_ovf_q  <= irq_ovf_d;
        end
    end

    assign fib_value  = cur_q;
    assign term_count = cnt_q;
    assign state_o    = state_q;
    assign busy       = busy_q;
    assign irq_done   = irq_done_q;
    assign irq_ovf    = irq_ovf_q;

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Scoreboard bench for fib_run_ctrl: an index-based Fibonacci reference model
// queues expected outputs each clock; a monitor pops and compares on the falling edge.
module tb_fib_run_ctrl;

    localparam int VW = 30;
    localparam int CW = 6;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          switch_i;
    logic [CW-1:0] clock_sel;
    logic          start;
    logic          stop;
    logic [NW-1:0] term_limit;
    logic [VW-1:0] fib_value;
    logic [NW-1:0] term_count;
    logic [2:0]    state_o;
    logic          busy;
    logic          irq_done;
    logic          irq_ovf;

    fib_run_ctrl #(.VALUE_WIDTH(VW), .CLOCK_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
        .wb_clk_i  (clk),
        .reset     (rst),
        .switch    (switch_i),
        .clock_sel (clock_sel),
        .start     (start),
        .stop      (stop),
        .term_limit(term_limit),
        .fib_value (fib_value),
        .term_count(term_count),
        .state_o   (state_o),
        .busy      (busy),
        .irq_done  (irq_done),
        .irq_ovf   (irq_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint fib;
        int     cnt;
        int     st;
        bit     bsy;
        bit     idone;
        bit     iovf;
    } exp_t;

    exp_t   sbq[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint fib[0:60];

    // Reference state: term index, prescaler count, latched limit, state code.
    int m_st, m_n, m_presc, m_lim, m_prev, m_k;
    bit m_tick;
    exp_t m_e;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        fib[0] = 0;
        fib[1] = 1;
        for (int i = 2; i <= 60; i++) fib[i] = fib[i-1] + fib[i-2];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_n = 0; m_presc = 0; m_lim = 0;
            sbq.delete();
        end else begin
            m_k = -1;
            for (int i = CW - 1; i >= 0; i--) if (clock_sel[i]) m_k = i;
            m_tick = (m_st == 1) && (m_k >= 0) && (((m_presc + 1) % (1 << m_k)) == 0);
            m_prev = m_st;
            if (stop && m_st != 0) begin
                m_st = 0;
            end else if (start && switch_i && !stop) begin
                m_st = 1; m_n = 0; m_presc = 0; m_lim = int'(term_limit);
            end else if (m_st == 1) begin
                m_presc = (m_presc + 1) % 32;
                if (m_tick && fib[m_n + 2] >= (64'd1 << VW)) begin
                    m_st = 4;
                end else begin
                    if (m_tick) m_n = (m_n == 65535) ? m_n : m_n + 1;
                    if (m_tick && m_lim != 0 && m_n == m_lim) m_st = 3;
                    else if (!switch_i) m_st = 2;
                end
            end else if (m_st == 2 && switch_i) begin
                m_st = 1;
            end
            m_e.fib   = fib[m_n];
            m_e.cnt   = m_n;
            m_e.st    = m_st;
            m_e.bsy   = (m_st == 1 || m_st == 2);
            m_e.idone = (m_st == 3 && m_prev != 3);
            m_e.iovf  = (m_st == 4 && m_prev != 4);
            sbq.push_back(m_e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("fib_value", fib_value, e.fib);
            check("term_count", term_count, e.cnt);
            check("state", state_o, e.st);
            check("busy", busy, e.bsy);
            check("irq_done", irq_done, e.idone);
            check("irq_ovf", irq_ovf, e.iovf);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input int s, input int lim, input string name);
        for (int i = 0; i < lim && state_o != 3'(s); i++) @(negedge clk);
        check(name, state_o, s);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fib"}, fib_value, 0);
        check({tag, "_cnt"}, term_count, 0);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_irq"}, {irq_done, irq_ovf}, 0);
    endtask

    initial begin
        rst = 1'b1; switch_i = 1'b0; clock_sel = 6'b000001;
        start = 1'b0; stop = 1'b0; term_limit = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ten terms at full rate.
        switch_i = 1'b1; clock_sel = 6'b000001; term_limit = 16'd10;
        pulse_start();
        wait_state(3, 100, "t1_done");
        check("t1_fib55", fib_value, 55);
        check("t1_cnt10", term_count, 10);
        repeat (5) @(negedge clk);

        // Divide-by-4 rate, three terms.
        clock_sel = 6'b000100; term_limit = 16'd3;
        pulse_start();
        wait_state(3, 100, "t2_done");
        check("t2_fib", fib_value, 2);
        repeat (5) @(negedge clk);

        // Free-run to width overflow.
        clock_sel = 6'b000001; term_limit = 16'd0;
        pulse_start();
        wait_state(4, 200, "t3_ovf");
        repeat (10) @(negedge clk);
        check("t3_fib43", fib_value, 433494437);
        check("t3_cnt43", term_count, 43);

        // Pause for 20 cycles mid-run, then resume.
        clock_sel = 6'b001000; term_limit = 16'd0;
        pulse_start();
        repeat (37) @(negedge clk);
        switch_i = 1'b0;
        repeat (20) @(negedge clk);
        check("t4_pause", state_o, 2);
        switch_i = 1'b1;
        repeat (50) @(negedge clk);

        // Stop beats start; start with switch low is ignored.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_idle", state_o, 0);
        switch_i = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        check("t5_ignored", state_o, 0);
        switch_i = 1'b1;

        // Asynchronous reset between edges mid-run.
        clock_sel = 6'b000001; term_limit = 16'd0;
        pulse_start();
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            switch_i = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 3) == 0) clock_sel = 6'($urandom);
                else clock_sel = 6'(1 << $urandom_range(0, 3));
            end
            start = ($urandom_range(0, 49) == 0);
            stop  = ($urandom_range(0, 99) == 0);
            term_limit = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 25));
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
